// File: rtl/harris_host.sv
// ---------------------------------------------------------------------------
// harris_host
//
// Host-side companion of the Harris HLS kernel. It runs the kernel's
// ap_ctrl_hs start/done handshake. It also owns the two memories the kernel
// talks to:
//   - an image buffer, which answers the kernel's single-port img reads;
//   - a result buffer, which captures the kernel's harris writes.
// A load port fills the image buffer, and a read-back port drains the results.
//
// Parameters
//   ADDR_W : kernel address width (img_address0 / harris_address0)
//   DATA_W : buffer word width
//   DEPTH  : words per buffer (must not exceed 2**ADDR_W)
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   cmd_start         : request one kernel run (honoured only when idle)
//   busy, done        : run in progress / one-cycle end-of-run pulse
//   cycles, wr_count  : START+RUN cycle count and harris write count of the
//                       last run (both saturating)
//   ld_valid/addr/data: image buffer load port
//   ld_err            : pulse, a load was attempted while busy and dropped
//   rd_en/addr        : result buffer read-back request
//   rd_data, rd_valid : read-back data (one cycle latency) and its strobe
//   ap_start          : kernel start
//   ap_ready/done/idle: kernel status (ap_idle is not used)
//   img_ce0/address0  : kernel image read request
//   img_q0            : kernel image read data (one cycle latency)
//   harris_ce0/we0/address0/d0 : kernel result write port
// ---------------------------------------------------------------------------
module harris_host #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  output logic              busy,
  output logic              done,
  output logic [31:0]       cycles,
  output logic [ADDR_W:0]   wr_count,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic              img_ce0,
  input  logic [ADDR_W-1:0] img_address0,
  output logic [DATA_W-1:0] img_q0,
  input  logic              harris_ce0,
  input  logic              harris_we0,
  input  logic [ADDR_W-1:0] harris_address0,
  input  logic [DATA_W-1:0] harris_d0
);

  // Width needed to index DEPTH words. It never exceeds ADDR_W, and only
  // in-range addresses ever reach the arrays.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;

  logic [DATA_W-1:0] img_mem [DEPTH];
  logic [DATA_W-1:0] res_mem [DEPTH];

  logic harris_wr;
  logic run_active;
  logic ld_ok;
  logic res_wr_ok;
  logic unused_ap_idle;

  // The kernel's idle flag carries no information the FSM needs.
  assign unused_ap_idle = ap_idle;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  assign harris_wr  = harris_ce0 & harris_we0;
  assign run_active = (state == S_START) || (state == S_RUN);

  // Host loads are only safe while the kernel cannot be reading the buffer.
  assign ld_ok     = ld_valid && !run_active && in_range(ld_addr);
  assign res_wr_ok = harris_wr && in_range(harris_address0);

  // Run-control FSM. Every output is registered, so each transition also
  // sets the values that the outputs will hold in the destination state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      ap_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cycles   <= '0;
      wr_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_start) begin
            state    <= S_START;
            ap_start <= 1'b1;
            busy     <= 1'b1;
            cycles   <= '0;
            wr_count <= '0;
          end
        end

        S_START, S_RUN: begin
          // The cycle in which ap_done is seen still counts as a run cycle.
          if (cycles != '1) begin
            cycles <= cycles + 32'd1;
          end
          if (harris_wr && (wr_count != '1)) begin
            wr_count <= wr_count + (ADDR_W + 1)'(1);
          end

          if (state == S_START) begin
            if (ap_ready) begin
              ap_start <= 1'b0;
              // A kernel may report ready and done in the same cycle. In
              // that case RUN is skipped.
              if (ap_done) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= S_RUN;
              end
            end
          end else if (ap_done) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          // cmd_start is deliberately ignored for this one cycle.
          state <= S_IDLE;
        end

        default: begin
          state    <= S_IDLE;
          ap_start <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Load-while-busy is reported one cycle later and the write is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_err <= 1'b0;
    end else begin
      ld_err <= ld_valid && run_active;
    end
  end

  // Buffer storage. These arrays have no reset, so contents survive rst.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      img_mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end
    if (res_wr_ok) begin
      res_mem[harris_address0[IDX_W-1:0]] <= harris_d0;
    end
  end

  // Kernel image read port. It has one cycle of latency and holds its value
  // while img_ce0 is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_q0 <= '0;
    end else if (img_ce0) begin
      img_q0 <= in_range(img_address0) ? img_mem[img_address0[IDX_W-1:0]] : '0;
    end
  end

  // Result read-back port. A same-cycle harris write to the same address
  // lands only at this edge, so the read returns the previous word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= in_range(rd_addr) ? res_mem[rd_addr[IDX_W-1:0]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_harris_host.sv
// ---------------------------------------------------------------------------
// tb_harris_host
//
// Self-checking bench for harris_host. A full-size instance (DEPTH=256) and a
// reduced instance (DEPTH=200) share every input. The reduced instance is
// only inspected for out-of-range behaviour and for in-range agreement.
// Reference state is kept as plain arrays of buffer words.
// ---------------------------------------------------------------------------
module tb_harris_host;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst;

  logic              cmd_start;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              ap_ready;
  logic              ap_done;
  logic              ap_idle;
  logic              img_ce0;
  logic [ADDR_W-1:0] img_address0;
  logic              harris_ce0;
  logic              harris_we0;
  logic [ADDR_W-1:0] harris_address0;
  logic [DATA_W-1:0] harris_d0;

  logic              busy, done, ld_err, rd_valid, ap_start;
  logic [31:0]       cycles;
  logic [ADDR_W:0]   wr_count;
  logic [DATA_W-1:0] rd_data, img_q0;

  logic              s_busy, s_done, s_ld_err, s_rd_valid, s_ap_start;
  logic [31:0]       s_cycles;
  logic [ADDR_W:0]   s_wr_count;
  logic [DATA_W-1:0] s_rd_data, s_img_q0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] img_model [256];
  logic [DATA_W-1:0] res_model [256];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_q;
  } img_vec_t;

  typedef struct {
    int ready_at;
    int done_at;
    int n_wr;
    int ld_at;
    bit cmd_in_done;
    int exp_cycles;
    int exp_wr;
  } run_vec_t;

  img_vec_t img_tab [5];
  run_vec_t run_tab [5];

  always #5 clk = ~clk;

  harris_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .busy(busy), .done(done),
    .cycles(cycles), .wr_count(wr_count), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_err(ld_err), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .img_ce0(img_ce0), .img_address0(img_address0), .img_q0(img_q0),
    .harris_ce0(harris_ce0), .harris_we0(harris_we0),
    .harris_address0(harris_address0), .harris_d0(harris_d0)
  );

  harris_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(200)) dut_small (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .busy(s_busy), .done(s_done),
    .cycles(s_cycles), .wr_count(s_wr_count), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_err(s_ld_err), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .ap_start(s_ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .img_ce0(img_ce0), .img_address0(img_address0), .img_q0(s_img_q0),
    .harris_ce0(harris_ce0), .harris_we0(harris_we0),
    .harris_address0(harris_address0), .harris_d0(harris_d0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete kernel run, with the kernel timing described by rv. Indices
  // count START/RUN cycles, starting from the first cycle with busy high.
  task automatic apply_stimulus(input run_vec_t rv, input string tag);
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    for (int k = 0; k <= rv.done_at; k++) begin
      check_output({tag, " ap_start"}, ap_start, (k <= rv.ready_at) ? 64'd1 : 64'd0);
      check_output({tag, " busy"}, busy, 64'd1);
      check_output({tag, " ld_err"}, ld_err,
                   (rv.ld_at >= 0 && k == rv.ld_at + 1) ? 64'd1 : 64'd0);
      ap_ready = (k == rv.ready_at);
      ap_done  = (k == rv.done_at);
      ld_valid = (k == rv.ld_at);
      ld_addr  = 8'd7;
      ld_data  = 32'hDEAD_BEEF;
      if (k < rv.n_wr) begin
        harris_ce0      = 1'b1;
        harris_we0      = 1'b1;
        harris_address0 = 8'(k);
        harris_d0       = $urandom;
        res_model[k % 256] = harris_d0;
      end else begin
        harris_ce0 = 1'b0;
        harris_we0 = 1'b0;
      end
      step();
    end
    ap_ready   = 1'b0;
    ap_done    = 1'b0;
    ld_valid   = 1'b0;
    harris_ce0 = 1'b0;
    harris_we0 = 1'b0;
    check_output({tag, " done pulse"}, done, 64'd1);
    check_output({tag, " busy at done"}, busy, 64'd0);
    check_output({tag, " ap_start at done"}, ap_start, 64'd0);
    check_output({tag, " cycles"}, cycles, 64'(rv.exp_cycles));
    check_output({tag, " wr_count"}, wr_count, 64'(rv.exp_wr));
    cmd_start = rv.cmd_in_done;
    step();
    cmd_start = 1'b0;
    check_output({tag, " done cleared"}, done, 64'd0);
    check_output({tag, " busy after done"}, busy, 64'd0);
    check_output({tag, " ap_start after done"}, ap_start, 64'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] old_v;
    logic [DATA_W-1:0] new_v;
    logic [DATA_W-1:0] exp_rd;
    logic [DATA_W-1:0] exp_img;
    logic              exp_rv;

    // Vectors. Image word i is loaded as i*3.
    img_tab[0] = '{addr: 8'd0,   exp_q: 32'd0};
    img_tab[1] = '{addr: 8'd1,   exp_q: 32'd3};
    img_tab[2] = '{addr: 8'd255, exp_q: 32'd765};
    img_tab[3] = '{addr: 8'd100, exp_q: 32'd300};
    img_tab[4] = '{addr: 8'd42,  exp_q: 32'd126};

    // Run 0: cmd at cycle 10, ready at 14, done at 40, which gives 30 cycles.
    run_tab[0] = '{ready_at: 3, done_at: 29, n_wr: 30, ld_at: -1, cmd_in_done: 1'b0,
                   exp_cycles: 30, exp_wr: 30};
    // Run 1: ready and done on the first START cycle, with cmd_start during DONE.
    run_tab[1] = '{ready_at: 0, done_at: 0, n_wr: 1, ld_at: -1, cmd_in_done: 1'b1,
                   exp_cycles: 1, exp_wr: 1};
    // Run 2: 256 writes and a load attempted while busy.
    run_tab[2] = '{ready_at: 2, done_at: 259, n_wr: 256, ld_at: 100, cmd_in_done: 1'b0,
                   exp_cycles: 260, exp_wr: 256};
    // Run 3: 520 writes, so wr_count saturates at 511.
    run_tab[3] = '{ready_at: 5, done_at: 524, n_wr: 520, ld_at: -1, cmd_in_done: 1'b0,
                   exp_cycles: 525, exp_wr: 511};
    // Run 4: normal run after a mid-run reset.
    run_tab[4] = '{ready_at: 1, done_at: 10, n_wr: 5, ld_at: -1, cmd_in_done: 1'b0,
                   exp_cycles: 11, exp_wr: 5};

    rst = 1'b1;
    cmd_start = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    rd_en = 1'b0; rd_addr = '0; ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
    img_ce0 = 1'b0; img_address0 = '0; harris_ce0 = 1'b0; harris_we0 = 1'b0;
    harris_address0 = '0; harris_d0 = '0;

    #3 rst = 1'b0;
    #1;
    check_output("reset ap_start", ap_start, 64'd0);
    check_output("reset busy", busy, 64'd0);
    check_output("reset done", done, 64'd0);
    check_output("reset ld_err", ld_err, 64'd0);
    check_output("reset rd_valid", rd_valid, 64'd0);
    check_output("reset img_q0", img_q0, 64'd0);
    check_output("reset rd_data", rd_data, 64'd0);
    check_output("reset cycles", cycles, 64'd0);
    check_output("reset wr_count", wr_count, 64'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // Load the image buffer.
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1;
      ld_addr  = 8'(i);
      ld_data  = 32'(i * 3);
      img_model[i] = 32'(i * 3);
      step();
    end
    ld_valid = 1'b0;

    // Kernel image reads issued on consecutive cycles.
    for (int i = 0; i < 5; i++) begin
      img_ce0      = 1'b1;
      img_address0 = img_tab[i].addr;
      step();
      check_output($sformatf("img read %0d", img_tab[i].addr), img_q0, 64'(img_tab[i].exp_q));
    end
    img_ce0      = 1'b0;
    img_address0 = 8'd9;
    step();
    check_output("img_q0 hold", img_q0, 64'(img_tab[4].exp_q));

    // Kernel runs.
    for (int r = 0; r < 4; r++) begin
      apply_stimulus(run_tab[r], $sformatf("run%0d", r));
    end
    step();
    check_output("cmd in DONE ignored", busy, 64'd0);

    // The load attempted during run 2 must not have landed.
    img_ce0      = 1'b1;
    img_address0 = 8'd7;
    step();
    img_ce0 = 1'b0;
    check_output("busy load dropped", img_q0, 64'(img_model[7]));

    // Read-first on the result buffer.
    old_v = res_model[5];
    new_v = ~old_v;
    rd_en = 1'b1; rd_addr = 8'd5;
    harris_ce0 = 1'b1; harris_we0 = 1'b1; harris_address0 = 8'd5; harris_d0 = new_v;
    step();
    harris_ce0 = 1'b0; harris_we0 = 1'b0;
    res_model[5] = new_v;
    check_output("read-first old", rd_data, 64'(old_v));
    check_output("read-first valid", rd_valid, 64'd1);
    step();
    check_output("read-first new", rd_data, 64'(new_v));
    rd_en = 1'b0;
    step();
    check_output("rd_valid low", rd_valid, 64'd0);
    check_output("rd_data hold", rd_data, 64'(new_v));

    // Out of range for the DEPTH=200 instance.
    harris_ce0 = 1'b1; harris_we0 = 1'b1; harris_address0 = 8'd210; harris_d0 = 32'h1234_5678;
    res_model[210] = 32'h1234_5678;
    step();
    harris_ce0 = 1'b0; harris_we0 = 1'b0;
    rd_en = 1'b1; rd_addr = 8'd210; img_ce0 = 1'b1; img_address0 = 8'd210;
    step();
    check_output("oor full rd_data", rd_data, 64'(res_model[210]));
    check_output("oor small rd_data", s_rd_data, 64'd0);
    check_output("oor small rd_valid", s_rd_valid, 64'd1);
    check_output("oor full img_q0", img_q0, 64'(img_model[210]));
    check_output("oor small img_q0", s_img_q0, 64'd0);
    rd_addr = 8'd150; img_ce0 = 1'b0;
    step();
    rd_en = 1'b0;
    check_output("small in-range rd", s_rd_data, 64'(res_model[150]));

    // Randomised idle traffic, checked against the array model.
    for (int i = 0; i < 300; i++) begin
      rd_en        = (i == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      rd_addr      = 8'($urandom_range(0, 255));
      img_ce0      = (i == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      img_address0 = 8'($urandom_range(0, 255));
      harris_ce0   = ($urandom_range(0, 1) == 1);
      harris_we0   = ($urandom_range(0, 3) != 0);
      harris_address0 = 8'($urandom_range(0, 255));
      harris_d0    = $urandom;
      ld_valid     = ($urandom_range(0, 3) == 0);
      ld_addr      = 8'($urandom_range(0, 255));
      if (img_ce0 && ld_addr == img_address0) ld_addr = ld_addr ^ 8'd1;
      ld_data      = $urandom;
      if (rd_en) exp_rd = res_model[rd_addr];
      if (img_ce0) exp_img = img_model[img_address0];
      exp_rv = rd_en;
      if (harris_ce0 && harris_we0) res_model[harris_address0] = harris_d0;
      if (ld_valid) img_model[ld_addr] = ld_data;
      step();
      check_output("rand rd_valid", rd_valid, 64'(exp_rv));
      check_output("rand rd_data", rd_data, 64'(exp_rd));
      check_output("rand img_q0", img_q0, 64'(exp_img));
    end
    rd_en = 1'b0; img_ce0 = 1'b0; harris_ce0 = 1'b0; harris_we0 = 1'b0; ld_valid = 1'b0;
    step();
    check_output("idle writes not counted", wr_count, 64'd511);
    check_output("idle ld_err", ld_err, 64'd0);

    // Mid-run reset.
    cmd_start = 1'b1;
    step();
    cmd_start = 1'b0;
    ap_ready  = 1'b1;
    step();
    ap_ready  = 1'b0;
    for (int j = 0; j < 4; j++) begin
      harris_ce0 = 1'b1; harris_we0 = 1'b1;
      harris_address0 = 8'(20 + j);
      harris_d0 = $urandom;
      res_model[20 + j] = harris_d0;
      step();
    end
    harris_ce0 = 1'b0; harris_we0 = 1'b0;
    check_output("pre-reset busy", busy, 64'd1);
    check_output("pre-reset cycles", cycles, 64'd5);
    check_output("pre-reset wr_count", wr_count, 64'd4);
    #2 rst = 1'b0;
    #1;
    check_output("async reset busy", busy, 64'd0);
    check_output("async reset ap_start", ap_start, 64'd0);
    check_output("async reset cycles", cycles, 64'd0);
    check_output("async reset wr_count", wr_count, 64'd0);
    check_output("async reset done", done, 64'd0);
    check_output("async reset img_q0", img_q0, 64'd0);
    step();
    step();
    rst = 1'b1;
    step();
    img_ce0 = 1'b1; img_address0 = 8'd100;
    step();
    img_ce0 = 1'b0;
    check_output("image kept over reset", img_q0, 64'(img_model[100]));
    apply_stimulus(run_tab[4], "run4");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so that a wedged run still reports.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 200000");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule
